// File: rtl/synapse_accumulator.sv
// Serial weighted-sum input stage: one synapse per clock, saturated sum pulsed for one cycle.
// Optional runtime weight loading is enabled by defining SYNAPSE_WEIGHT_LOAD_EN.
module synapse_accumulator #(
    parameter int N_INPUTS    = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int DATA_LENGTH = 16,
    parameter int INIT_WEIGHT = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_tick,
    input  logic [N_INPUTS-1:0]         i_pre_spike,
    output logic [DATA_LENGTH-1:0]      o_spike_sum,
    output logic                        o_valid,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic [1:0]                  o_dbg_state
`ifdef SYNAPSE_WEIGHT_LOAD_EN
    ,
    input  logic                        i_w_we,
    input  logic [$clog2(N_INPUTS)-1:0] i_w_addr,
    input  logic [WEIGHT_BITS-1:0]      i_w_data
`endif
);

    localparam int IDX_W = $clog2(N_INPUTS);
    localparam int ACC_W = DATA_LENGTH + IDX_W;
    localparam logic [WEIGHT_BITS-1:0] INIT_W  = WEIGHT_BITS'(INIT_WEIGHT);
    localparam logic [ACC_W-1:0]       SUM_MAX = (ACC_W'(1) << DATA_LENGTH) - ACC_W'(1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_INPUTS - 1);

    // Handshake: i_tick is a request honoured only in IDLE; o_valid is a
    // one-cycle strobe with no back-pressure, o_spike_sum is 0 whenever o_valid=0.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]       idx;
    logic [N_INPUTS-1:0]    vec;
    logic [WEIGHT_BITS-1:0] w [N_INPUTS];
    logic [WEIGHT_BITS-1:0] cur_w;
    logic [ACC_W-1:0]       addend;
    logic [ACC_W-1:0]       acc_sum;
    logic                   last_step;

`ifdef SYNAPSE_WEIGHT_LOAD_EN
    // Writes land at the clock edge, so a same-cycle scan read sees the old weight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                w[i] <= INIT_W;
            end
        end else if (i_w_we && (int'(i_w_addr) < N_INPUTS)) begin
            w[i_w_addr] <= i_w_data;
        end
    end
`else
    for (genvar g = 0; g < N_INPUTS; g++) begin : g_const_w
        assign w[g] = INIT_W;
    end
`endif

    assign cur_w     = w[idx];
    assign addend    = vec[idx] ? ACC_W'(cur_w) : '0;
    assign acc_sum   = acc + addend;
    assign last_step = (idx == LAST_IDX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (i_tick) state_next = S_SCAN;
            S_SCAN:  if (last_step) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc         <= '0;
            idx         <= '0;
            vec         <= '0;
            o_spike_sum <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun <= i_tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_tick) begin
                        vec <= i_pre_spike;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_SCAN: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (last_step) begin
                        o_spike_sum <= (acc_sum > SUM_MAX) ? '1 : acc_sum[DATA_LENGTH-1:0];
                        o_valid     <= 1'b1;
                    end
                end
                S_DONE: begin
                    o_spike_sum <= '0;
                    o_valid     <= 1'b0;
                end
                default: begin
                    o_spike_sum <= '0;
                    o_valid     <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_dbg_state = state;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Randomised scoreboard bench for synapse_accumulator: default instance plus a saturating
// DATA_LENGTH=8 / INIT_WEIGHT=255 instance.
module tb_synapse_accumulator;

    localparam int N   = 8;
    localparam int DL  = 16;
    localparam int DLS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tick, tick_s;
    logic [N-1:0]  pre, pre_s;
    logic [DL-1:0] sum;
    logic [DLS-1:0] sum_s;
    logic          valid, busy, overrun, valid_s, busy_s, overrun_s;
    logic [1:0]    dbg_state, dbg_state_s;
`ifdef SYNAPSE_WEIGHT_LOAD_EN
    logic          w_we;
    logic [2:0]    w_addr;
    logic [7:0]    w_data;
`endif

    synapse_accumulator dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_pre_spike(pre),
        .o_spike_sum(sum), .o_valid(valid), .o_busy(busy), .o_overrun(overrun),
        .o_dbg_state(dbg_state)
`ifdef SYNAPSE_WEIGHT_LOAD_EN
        , .i_w_we(w_we), .i_w_addr(w_addr), .i_w_data(w_data)
`endif
    );

    synapse_accumulator #(.DATA_LENGTH(DLS), .INIT_WEIGHT(255)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_tick(tick_s), .i_pre_spike(pre_s),
        .o_spike_sum(sum_s), .o_valid(valid_s), .o_busy(busy_s), .o_overrun(overrun_s),
        .o_dbg_state(dbg_state_s)
`ifdef SYNAPSE_WEIGHT_LOAD_EN
        , .i_w_we(1'b0), .i_w_addr(3'd0), .i_w_data(8'd0)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: weights, expected results and the cycles they are due.
    int              m_w [N];
    int              next_free = 0;
    logic [DL-1:0]   exp_q[$];
    int              exp_cyc_q[$];
    int              ov_q[$];
    logic [DLS-1:0]  exp_s_q[$];
    bit              prev_valid = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DL-1:0] model_sum(input logic [N-1:0] v);
        longint s = 0;
        for (int i = 0; i < N; i++) if (v[i]) s += m_w[i];
        if (s > 65535) s = 65535;
        return DL'(s);
    endfunction

    function automatic logic [DLS-1:0] model_sat(input logic [N-1:0] v);
        longint s = 0;
        for (int i = 0; i < N; i++) if (v[i]) s += 255;
        if (s > 255) s = 255;
        return DLS'(s);
    endfunction

    // A tick driven for edge e is accepted only if the block is idle at e.
    task automatic drive_tick(input logic [N-1:0] v);
        int e;
        @(negedge clk);
        tick = 1'b1;
        pre  = v;
        e    = cyc + 1;
        if (e >= next_free) begin
            exp_q.push_back(model_sum(v));
            exp_cyc_q.push_back(e + N);
            next_free = e + N + 2;
        end else begin
            ov_q.push_back(e);
        end
        @(negedge clk);
        tick = 1'b0;
        pre  = N'($urandom);
    endtask

    task automatic drive_tick_sat(input logic [N-1:0] v);
        @(negedge clk);
        tick_s = 1'b1;
        pre_s  = v;
        exp_s_q.push_back(model_sat(v));
        @(negedge clk);
        tick_s = 1'b0;
        pre_s  = N'($urandom);
        repeat (12) @(negedge clk);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check(valid == 1'b0, "rst_async_valid", valid, 0);
        check(sum == '0, "rst_async_sum", sum, 0);
        check(busy == 1'b0, "rst_async_busy", busy, 0);
        check(overrun == 1'b0, "rst_async_overrun", overrun, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        ov_q.delete();
        next_free  = 0;
        prev_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_valid", sum, 0);
                end else begin
                    logic [DL-1:0] e_sum;
                    int            e_cyc;
                    e_sum = exp_q.pop_front();
                    e_cyc = exp_cyc_q.pop_front();
                    check(sum == e_sum, "spike_sum", sum, e_sum);
                    check(cyc == e_cyc, "valid_latency", cyc, e_cyc);
                end
            end else begin
                check(sum == '0, "sum_zero_when_idle", sum, 0);
                if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                    check(1'b0, "missing_valid", 0, exp_q[0]);
                    void'(exp_cyc_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
            if (prev_valid) check(busy == 1'b0, "busy_after_valid", busy, 0);
            if (overrun) begin
                if (ov_q.size() == 0) begin
                    check(1'b0, "unexpected_overrun", 1, 0);
                end else begin
                    int e_ov;
                    e_ov = ov_q.pop_front();
                    check(cyc == e_ov, "overrun_cycle", cyc, e_ov);
                end
            end else if (ov_q.size() > 0 && ov_q[0] < cyc) begin
                check(1'b0, "missing_overrun", 0, 1);
                void'(ov_q.pop_front());
            end
            prev_valid = valid;
        end
    end

    // Monitor for the saturating instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_s) begin
                if (exp_s_q.size() == 0) begin
                    check(1'b0, "sat_unexpected_valid", sum_s, 0);
                end else begin
                    logic [DLS-1:0] e_s;
                    e_s = exp_s_q.pop_front();
                    check(sum_s == e_s, "sat_spike_sum", sum_s, e_s);
                end
            end else begin
                check(sum_s == '0, "sat_sum_zero_when_idle", sum_s, 0);
            end
            check(overrun_s == 1'b0, "sat_no_overrun", overrun_s, 0);
        end
    end

    initial begin
        int budget;
        for (int i = 0; i < N; i++) m_w[i] = 16;
        rst    = 1'b1;
        tick   = 1'b0;
        tick_s = 1'b0;
        pre    = '0;
        pre_s  = '0;
`ifdef SYNAPSE_WEIGHT_LOAD_EN
        w_we   = 1'b0;
        w_addr = '0;
        w_data = '0;
`endif
        repeat (3) @(negedge clk);
        check(valid == 1'b0, "reset_valid", valid, 0);
        check(sum == '0, "reset_sum", sum, 0);
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(overrun == 1'b0, "reset_overrun", overrun, 0);
        check(busy_s == 1'b0, "reset_sat_busy", busy_s, 0);
        #2 rst = 1'b0;

        drive_tick(8'b1010_0101);
        repeat (12) @(negedge clk);
        drive_tick(8'h00);
        repeat (12) @(negedge clk);

        // Second tick while scanning must be dropped with an overrun pulse.
        drive_tick(8'hF0);
        repeat (1) @(negedge clk);
        drive_tick(8'h33);
        repeat (12) @(negedge clk);

        drive_tick(8'hF0);
        repeat (3) @(negedge clk);
        mid_reset();
        drive_tick(8'h01);
        repeat (12) @(negedge clk);

`ifdef SYNAPSE_WEIGHT_LOAD_EN
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = 3'd3;
        w_data = 8'd200;
        @(negedge clk);
        w_we   = 1'b0;
        m_w[3] = 200;
        drive_tick(8'h08);
        repeat (12) @(negedge clk);
`endif

        for (int k = 0; k < 30; k++) begin
            drive_tick(N'($urandom));
            repeat ($urandom_range(0, 11)) @(negedge clk);
        end
        repeat (12) @(negedge clk);

        drive_tick_sat(8'hFF);
        drive_tick_sat(8'h00);
        drive_tick_sat(8'h01);
        for (int k = 0; k < 4; k++) drive_tick_sat(N'($urandom));

        budget = 0;
        while ((exp_q.size() + ov_q.size() + exp_s_q.size()) != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check(exp_q.size() == 0, "drain_results", exp_q.size(), 0);
        check(ov_q.size() == 0, "drain_overruns", ov_q.size(), 0);
        check(exp_s_q.size() == 0, "drain_sat_results", exp_s_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
